// File: rtl/lbm_pkg.sv
// Shared types and constants for the LBM velocity divider.
// The divider's optional saturation build is selected with DIV_SATURATE_EN.
package lbm_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned FRAC_BITS_DEF  = 16;

    // Saturation limits for the default Q16.16 word
    localparam logic [DATA_WIDTH_DEF-1:0] FIX_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_WIDTH_DEF-1:0] FIX_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift one dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import lbm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH:0]   i_rem,
    input  logic                  i_bit,
    input  logic [DATA_WIDTH-1:0] i_div,
    output logic [DATA_WIDTH:0]   o_rem,
    output logic                  o_q
);

    logic [DATA_WIDTH+1:0] w_shift;
    logic [DATA_WIDTH+1:0] w_divisor;

    // Trial subtraction; keep the shifted remainder when the divisor does not fit
    always_comb begin
        w_shift   = {i_rem, i_bit};
        w_divisor = (DATA_WIDTH+2)'(i_div);
        o_q       = (w_shift >= w_divisor);
        o_rem     = o_q ? (DATA_WIDTH+1)'(w_shift - w_divisor)
                        : (DATA_WIDTH+1)'(w_shift);
    end

endmodule

// File: rtl/moment_divider.sv
// Sequential signed fixed-point divider producing ux = pux/p and uy = puy/p
// in lockstep for the LBM controller's div_start/div_valid handshake.
// Define DIV_SATURATE_EN to saturate out-of-range quotients; otherwise the
// low DATA_WIDTH bits of the signed quotient are returned.
module moment_divider
    import lbm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] p_in,
    input  logic [DATA_WIDTH-1:0] pux_in,
    input  logic [DATA_WIDTH-1:0] puy_in,
    output logic                  div_valid,
    output logic                  div_busy,
    output logic [DATA_WIDTH-1:0] ux_out,
    output logic [DATA_WIDTH-1:0] uy_out,
    output logic                  div_by_zero
);

    localparam int unsigned N  = DATA_WIDTH + FRAC_BITS;
    localparam int unsigned CW = $clog2(N);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t            r_state;
    div_state_t            w_state_next;
    logic [CW-1:0]         r_cnt;

    logic [DATA_WIDTH-1:0] r_div;
    logic                  r_p_zero;
    logic                  r_sx;
    logic                  r_sy;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom
    logic [N-1:0]          r_num_x;
    logic [N-1:0]          r_num_y;
    logic [DATA_WIDTH:0]   r_rem_x;
    logic [DATA_WIDTH:0]   r_rem_y;

    logic [DATA_WIDTH-1:0] r_ux;
    logic [DATA_WIDTH-1:0] r_uy;
    logic                  r_dbz;
    logic                  r_valid;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0] w_mag_p;
    logic [DATA_WIDTH-1:0] w_mag_x;
    logic [DATA_WIDTH-1:0] w_mag_y;
    logic [DATA_WIDTH:0]   w_rem_x;
    logic [DATA_WIDTH:0]   w_rem_y;
    logic                  w_q_x;
    logic                  w_q_y;
    logic [DATA_WIDTH-1:0] w_res_x;
    logic [DATA_WIDTH-1:0] w_res_y;

    // Operand magnitudes; the most-negative value maps to unsigned 2^(DATA_WIDTH-1)
    always_comb begin
        w_mag_p = p_in[DATA_WIDTH-1]   ? DATA_WIDTH'(-p_in)   : p_in;
        w_mag_x = pux_in[DATA_WIDTH-1] ? DATA_WIDTH'(-pux_in) : pux_in;
        w_mag_y = puy_in[DATA_WIDTH-1] ? DATA_WIDTH'(-puy_in) : puy_in;
    end

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step_x (
        .i_rem (r_rem_x),
        .i_bit (r_num_x[N-1]),
        .i_div (r_div),
        .o_rem (w_rem_x),
        .o_q   (w_q_x)
    );

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step_y (
        .i_rem (r_rem_y),
        .i_bit (r_num_y[N-1]),
        .i_div (r_div),
        .o_rem (w_rem_y),
        .o_q   (w_q_y)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (div_start) w_state_next = ITER;
            ITER:    if (r_cnt == '0) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Sign application, overflow handling and divide-by-zero override
    always_comb begin
        w_res_x = r_sx ? DATA_WIDTH'(-r_num_x[DATA_WIDTH-1:0]) : r_num_x[DATA_WIDTH-1:0];
        w_res_y = r_sy ? DATA_WIDTH'(-r_num_y[DATA_WIDTH-1:0]) : r_num_y[DATA_WIDTH-1:0];
`ifdef DIV_SATURATE_EN
        if (|r_num_x[N-1:DATA_WIDTH-1]) begin
            w_res_x = r_sx ? SAT_MIN : SAT_MAX;
        end
        if (|r_num_y[N-1:DATA_WIDTH-1]) begin
            w_res_y = r_sy ? SAT_MIN : SAT_MAX;
        end
`endif
        if (r_p_zero) begin
            w_res_x = '0;
            w_res_y = '0;
        end
    end

    // Operand latch, iteration datapath, result and status registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_cnt    <= '0;
            r_div    <= '0;
            r_p_zero <= 1'b0;
            r_sx     <= 1'b0;
            r_sy     <= 1'b0;
            r_num_x  <= '0;
            r_num_y  <= '0;
            r_rem_x  <= '0;
            r_rem_y  <= '0;
            r_ux     <= '0;
            r_uy     <= '0;
            r_dbz    <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_start) begin
                        r_div    <= w_mag_p;
                        r_p_zero <= (p_in == '0);
                        r_sx     <= pux_in[DATA_WIDTH-1] ^ p_in[DATA_WIDTH-1];
                        r_sy     <= puy_in[DATA_WIDTH-1] ^ p_in[DATA_WIDTH-1];
                        r_num_x  <= {w_mag_x, FRAC_BITS'(0)};
                        r_num_y  <= {w_mag_y, FRAC_BITS'(0)};
                        r_rem_x  <= '0;
                        r_rem_y  <= '0;
                        r_cnt    <= CW'(N - 1);
                    end
                end
                ITER: begin
                    r_rem_x <= w_rem_x;
                    r_rem_y <= w_rem_y;
                    r_num_x <= {r_num_x[N-2:0], w_q_x};
                    r_num_y <= {r_num_y[N-2:0], w_q_y};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                FIX: begin
                    r_ux  <= w_res_x;
                    r_uy  <= w_res_y;
                    r_dbz <= r_p_zero;
                end
                default: ;
            endcase
            r_valid <= (w_state_next == DONE);
            r_busy  <= (w_state_next != IDLE);
        end
    end

    assign div_valid   = r_valid;
    assign div_busy    = r_busy;
    assign ux_out      = r_ux;
    assign uy_out      = r_uy;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_moment_divider.sv
// Scoreboard bench for moment_divider (Q16.16 defaults). Expected values
// depend on whether DIV_SATURATE_EN is defined for the build.
module tb_moment_divider;
    import lbm_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned N   = 48;
    localparam int unsigned LAT = N + 1;   // edges from start-sampling edge to the div_valid edge

    typedef struct {
        logic [31:0] ux;
        logic [31:0] uy;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] p     = '0;
    logic [DW-1:0] x     = '0;
    logic [DW-1:0] y     = '0;
    logic          div_valid;
    logic          div_busy;
    logic [DW-1:0] ux_out;
    logic [DW-1:0] uy_out;
    logic          div_by_zero;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    moment_divider dut (
        .Clk         (clk),
        .Reset       (rst_n),
        .div_start   (start),
        .p_in        (p),
        .pux_in      (x),
        .puy_in      (y),
        .div_valid   (div_valid),
        .div_busy    (div_busy),
        .ux_out      (ux_out),
        .uy_out      (uy_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every div_valid pulse pops one expectation and checks it
    always @(negedge clk) begin
        if (div_valid) begin
            chk("valid_one_cycle", 32'(prev_valid), 32'd0);
            if (!prev_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid at cycle %0d: got pulse, expected none", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ux", ux_out, mon_e.ux);
                    chk("uy", uy_out, mon_e.uy);
                    chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                    chk("latency", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
        prev_valid = div_valid;
    end

    task automatic push_exp(input logic [31:0] eux, input logic [31:0] euy,
                            input logic edbz, input int start_cyc);
        exp_t e;
        e.ux  = eux;
        e.uy  = euy;
        e.dbz = edbz;
        e.cyc = start_cyc + int'(LAT);
        sb_q.push_back(e);
    endtask

    task automatic launch(input logic [31:0] ip, input logic [31:0] ix, input logic [31:0] iy,
                          input logic [31:0] eux, input logic [31:0] euy, input logic edbz);
        @(negedge clk);
        p = ip; x = ix; y = iy; start = 1'b1;
        @(negedge clk);
        push_exp(eux, euy, edbz, cyc);
        start = 1'b0;
        chk("busy", 32'(div_busy), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!div_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!div_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no div_valid within 200 cycles, expected one", name);
        end
    endtask

    task automatic run_op(input logic [31:0] ip, input logic [31:0] ix, input logic [31:0] iy,
                          input logic [31:0] eux, input logic [31:0] euy, input logic edbz);
        launch(ip, ix, iy, eux, euy, edbz);
        wait_valid("op_done");
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ux"},    ux_out, 32'd0);
        chk({tag, "_uy"},    uy_out, 32'd0);
        chk({tag, "_dbz"},   32'(div_by_zero), 32'd0);
        chk({tag, "_valid"}, 32'(div_valid), 32'd0);
        chk({tag, "_busy"},  32'(div_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected the bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // Basic quotients, divide by zero, overflow and extreme operands
        run_op(32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000, 1'b0);
        run_op(32'h0000_0000, 32'h0003_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1);
`ifdef DIV_SATURATE_EN
        run_op(32'h0000_0001, 32'h0001_0000, 32'hFFFF_0000, FIX_MAX, FIX_MIN, 1'b0);
        run_op(32'h0000_8000, 32'h7FFF_FFFF, 32'h4000_0000, FIX_MAX, FIX_MAX, 1'b0);
`else
        run_op(32'h0000_0001, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_op(32'h0000_8000, 32'h7FFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFE, 32'h8000_0000, 1'b0);
`endif
        run_op(32'h0003_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_5555, 32'hFFFF_AAAB, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0001_0000, 32'hFFFF_8000, 1'b0);
        run_op(32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        run_op(32'hFFFE_0000, 32'h0003_0000, 32'hFFFD_0000, 32'hFFFE_8000, 32'h0001_8000, 1'b0);

        // Starts during a busy operation are ignored, including one in DONE
        launch(32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000, 1'b0);
        repeat (4) @(negedge clk);
        p = 32'h0001_0000; x = 32'h0005_0000; y = 32'h0007_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("busy_ignore");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        chk("hold_ux", ux_out, 32'h0000_8000);
        chk("hold_uy", uy_out, 32'hFFFF_8000);
        chk("hold_busy", 32'(div_busy), 32'd0);

        // Reset in the middle of an operation aborts it
        launch(32'h0001_0000, 32'h0005_0000, 32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sb_q.delete();
        check_cleared("abort");
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check_cleared("after_abort");
        run_op(32'h0001_0000, 32'h0003_0000, 32'hFFFE_8000, 32'h0003_0000, 32'hFFFE_8000, 1'b0);

        // div_start held high: back-to-back operations every N+3 cycles
        @(negedge clk);
        p = 32'h0002_0000; x = 32'h0001_0000; y = 32'hFFFF_0000; start = 1'b1;
        @(negedge clk);
        push_exp(32'h0000_8000, 32'hFFFF_8000, 1'b0, cyc);
        repeat (3) @(negedge clk);
        p = 32'hDEAD_BEEF; x = 32'h1234_5678; y = 32'h8765_4321;
        wait_valid("held_a");
        p = 32'h0000_0000; x = 32'h0001_0000; y = 32'h0001_0000;
        push_exp(32'h0000_0000, 32'h0000_0000, 1'b1, cyc + 2);
        wait_valid("held_b");
        p = 32'h0004_0000; x = 32'h0001_0000; y = 32'hFFFC_0000;
        push_exp(32'h0000_4000, 32'hFFFF_0000, 1'b0, cyc + 2);
        wait_valid("held_c");
        start = 1'b0;

        repeat (70) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("final_busy", 32'(div_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/moment_divider.md
# moment_divider

Sequential signed fixed-point divider that answers the LBM controller's `div_start`/`div_valid` handshake. It computes both lattice velocities from one set of moment-register values in parallel: `ux = pux / p` and `uy = puy / p`. It sits between the p/pux/puy moment registers and the ux/uy load registers.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of operands and results, two's complement.
- `FRAC_BITS`, 16: fractional bits of the fixed-point format (default Q16.16).

Ports:
- `Clk` in 1: clock.
- `Reset` in 1: one clock; reset is synchronous and active-low.
- `div_start` in 1: request; sampled only in IDLE.
- `p_in` in DATA_WIDTH: denominator (density).
- `pux_in` in DATA_WIDTH: numerator for ux.
- `puy_in` in DATA_WIDTH: numerator for uy.
- `div_valid` out 1: one-cycle completion pulse.
- `div_busy` out 1: high in every state except IDLE.
- `ux_out` out DATA_WIDTH: quotient pux/p, held until the next accepted start.
- `uy_out` out DATA_WIDTH: quotient puy/p, held until the next accepted start.
- `div_by_zero` out 1: set when the last operation had `p_in == 0`; held with the results.

## Operation
- States: IDLE, ITER, FIX, DONE.
  - IDLE → ITER when `div_start` is 1.
  - ITER → FIX when the iteration counter reaches 0.
  - FIX → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Operand latch, on the IDLE→ITER edge:
  - Store the magnitudes of all three operands and the sign of each quotient (sign of numerator XOR sign of p).
  - Extend each numerator to N = DATA_WIDTH+FRAC_BITS bits and shift it left by FRAC_BITS.
  - Load the counter with N-1.
- ITER:
  - Radix-2 restoring division, one quotient bit per cycle, both quotients in lockstep against the shared divisor magnitude.
  - The partial remainder is DATA_WIDTH+1 bits wide.
- FIX:
  - Apply the sign by two's-complement negation.
  - Rounding is truncation toward zero.
  - Apply the overflow rule (see Configuration).
  - Write `ux_out`, `uy_out` and `div_by_zero`.
- DONE: `div_valid` = 1 for exactly this cycle.
- `p == 0`:
  - Iterations still run, so latency is unchanged.
  - FIX forces both results to 0 and sets `div_by_zero` = 1.
- Most-negative operand (0x80000000): its magnitude must be handled as an unsigned 2^(DATA_WIDTH-1) with no wrap.
- `div_start` outside IDLE is ignored. No queueing and no restart.
- `div_start` held high through DONE starts a new operation on the next IDLE cycle, latching the operands present at that cycle.
- Operands may change freely after the latch edge.

## Timing
- Reset (`Reset` low at a rising edge):
  - state = IDLE, counter = 0.
  - `ux_out` = 0, `uy_out` = 0, `div_by_zero` = 0, `div_valid` = 0, `div_busy` = 0.
- Reset mid-operation aborts the operation. No `div_valid` is produced for it, and the outputs return to 0.
- Latency: `div_start` sampled at edge 0 gives `div_valid` high during cycle N+2.
  - With default parameters, N = 48 and `div_valid` is high in cycle 50.
  - The next start can be accepted at edge N+3.
- `ux_out`/`uy_out` are valid from the `div_valid` cycle onward and are stable until FIX of the next operation. This lets the controller load them one cycle after seeing `div_valid`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DIV_SATURATE_EN` defined:
  - A magnitude quotient that does not fit in DATA_WIDTH-1 bits saturates.
  - Positive results saturate to 0x7FF…F; negative results saturate to 0x800…0.
- `DIV_SATURATE_EN` undefined: results are truncated to the low DATA_WIDTH bits of the signed quotient.
- The divide-by-zero behaviour is the same in both builds.

## Structure
- The shared package `lbm_pkg` holds:
  - the `div_state_t` enum (IDLE, ITER, FIX, DONE);
  - the `DATA_WIDTH`/`FRAC_BITS` defaults;
  - the saturation constants `FIX_MAX`/`FIX_MIN`.
- Sub-module `div_step`:
  - Purely combinational single restoring step: remainder and shift-in bit in; next remainder and quotient bit out.
  - Instantiated twice, once for ux and once for uy.
- The state machine, counter and sign/saturation logic live in `moment_divider`.

## Test plan
- p=0x00020000, pux=0x00010000, puy=0xFFFF0000, start pulse → `div_valid` in cycle 50; ux=0x00008000, uy=0xFFFF8000, `div_by_zero`=0.
- p=0x00000000, pux=0x00030000 → `div_valid` in cycle 50; ux=0, uy=0, `div_by_zero`=1.
- p=0x00000001, pux=0x00010000, puy=0xFFFF0000:
  - with `DIV_SATURATE_EN` → ux=0x7FFFFFFF, uy=0x80000000;
  - without it → ux=0x00000000, uy=0x00000000 (low 32 bits).
- `div_start` pulsed again at cycles 5 and 50 during a busy operation → no effect; exactly one `div_valid`, results unchanged.
- Reset asserted at cycle 20 of an operation → `div_valid` never pulses and outputs read 0. A new start at p=0x00010000, pux=0x00030000 then gives ux=0x00030000.
- `div_start` held high continuously → `div_valid` pulses every 51 cycles, and each result reflects the operands present at the respective IDLE cycle.
